// File: rtl/game_pkg.sv
// Shared game constants, the board cell encoding and a byte-lane insert helper
// used by the board readers and serializers.
package game_pkg;

    localparam int         BOARD_DIM       = 10;
    localparam int         N_CELLS         = BOARD_DIM * BOARD_DIM;
    localparam int         BYTES_PER_FRAME = N_CELLS / 4;
    localparam logic [7:0] HEADER_BYTE     = 8'hA5;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        SHIP  = 2'b01,
        HIT   = 2'b10,
        MISS  = 2'b11
    } cell_code_t;

    // Cell in lane n occupies bits [2n+1:2n] of a packed byte.
    function automatic logic [7:0] insert_lane(input logic [7:0]  b,
                                               input logic [1:0]  lane,
                                               input cell_code_t  code);
        logic [7:0] r;
        r = b;
        r[{lane, 1'b0} +: 2] = code;
        return r;
    endfunction

endpackage

// File: rtl/board_byte_packer.sv
// Collects four 2-bit cell codes into one byte, lowest lane first.
module board_byte_packer
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [1:0] code,
    output logic [7:0] data,
    output logic       last_lane
);

    logic [1:0] lane_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= 2'd0;
            data   <= 8'd0;
        end else if (clear) begin
            lane_q <= 2'd0;
            data   <= 8'd0;
        end else if (load) begin
            data   <= insert_lane(data, lane_q, cell_code_t'(code));
            lane_q <= lane_q + 2'd1;
        end
    end

    assign last_lane = (lane_q == 2'd3);

endmodule

// File: rtl/board_tx_serializer.sv
// Scans the 100-cell board and streams a framed, 4-cells-per-byte image to the UART TX.
// Define BOARD_TX_CHECKSUM_EN to append an XOR checksum byte (header included).
module board_tx_serializer #(
    parameter int         N_CELLS     = game_pkg::N_CELLS,
    parameter logic [7:0] HEADER_BYTE = game_pkg::HEADER_BYTE,
    parameter int         READ_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] ship_code,
    output logic [6:0] ship_xy,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        SEND,
`ifdef BOARD_TX_CHECKSUM_EN
        CSUM,
`endif
        FIN
    } state_t;

    localparam logic [6:0] LAST_CELL = 7'(N_CELLS - 1);
    localparam logic [6:0] END_CELL  = 7'(N_CELLS);
    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT);

    state_t     state_q, state_d;
    logic [6:0] k_q, k_inc;
    logic [1:0] wait_q;
    logic       xfer, rd_sample, byte_full;
    logic       pk_clear, pk_load, pk_last_lane;
    logic [7:0] pk_data;

    // Handshake: a byte moves on a rising edge with tx_valid && tx_ready; once
    // tx_valid is raised, tx_data stays fixed until that transfer (or reset).
    assign xfer      = tx_valid && tx_ready;
    // ship_code reflects ship_xy READ_LAT edges after it changes; captured one edge later.
    assign rd_sample = (state_q == RD) && (wait_q == WAIT_LAST);
    assign byte_full = pk_last_lane || (k_q == LAST_CELL);
    assign k_inc     = (k_q == END_CELL) ? k_q : k_q + 7'd1;

`ifdef BOARD_TX_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum_q <= 8'd0;
        else if (state_q == IDLE && start)
            csum_q <= 8'd0;
        else if (xfer && (state_q == HDR || state_q == SEND))
            csum_q <= csum_q ^ tx_data;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pk_clear = 1'b0;
        pk_load  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d  = HDR;
                    pk_clear = 1'b1;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER_BYTE;
                if (xfer) state_d = RD;
            end
            RD: begin
                if (rd_sample) begin
                    pk_load = 1'b1;
                    if (byte_full) state_d = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = pk_data;
                if (xfer) begin
                    pk_clear = 1'b1;
`ifdef BOARD_TX_CHECKSUM_EN
                    state_d  = (k_q == END_CELL) ? CSUM : RD;
`else
                    state_d  = (k_q == END_CELL) ? FIN : RD;
`endif
                end
            end
`ifdef BOARD_TX_CHECKSUM_EN
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (xfer) state_d = FIN;
            end
`endif
            FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Cell index, read-wait counter and the address presented to the board.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= 7'd0;
            wait_q  <= 2'd0;
            ship_xy <= 7'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        k_q     <= 7'd0;
                        wait_q  <= 2'd0;
                        ship_xy <= 7'd0;
                    end
                end
                RD: begin
                    if (rd_sample) begin
                        k_q    <= k_inc;
                        wait_q <= 2'd0;
                        if (!byte_full) ship_xy <= k_inc;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                SEND: begin
                    if (xfer) ship_xy <= (k_q == END_CELL) ? 7'd0 : k_q;
                end
                default: ;
            endcase
        end
    end

    board_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .load      (pk_load),
        .code      (ship_code),
        .data      (pk_data),
        .last_lane (pk_last_lane)
    );

endmodule

// File: tb/tb_board_tx_serializer.sv
// Bench for board_tx_serializer: two instances (READ_LAT 1 and 2) share stimulus,
// each reading its own delayed board model; frames are checked against a byte queue.
module tb_board_tx_serializer;

    localparam int NC = 100;
`ifdef BOARD_TX_CHECKSUM_EN
    localparam int FRAME_LEN = 27;
`else
    localparam int FRAME_LEN = 26;
`endif

    logic       clk = 1'b0;
    logic       rst, start, tx_ready;
    logic [1:0] code0, code1, r1;
    logic [6:0] xy0, xy1;
    logic [7:0] txd0, txd1;
    logic       txv0, txv1, busy0, busy1, done0, done1;

    logic [1:0] board [NC];
    logic [7:0] frame [FRAME_LEN];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    int         checks = 0;
    int         errors = 0;
    int         xfers  [2];
    int         dones  [2];
    int         xy_max [2];
    bit         active [2];
    bit         pv     [2];
    logic [7:0] pd     [2];
    logic [6:0] pxy    [2];

    always #5 clk = ~clk;

    board_tx_serializer #(.READ_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .ship_code(code0), .ship_xy(xy0),
        .tx_ready(tx_ready), .tx_data(txd0), .tx_valid(txv0), .busy(busy0), .done(done0)
    );

    board_tx_serializer #(.READ_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .ship_code(code1), .ship_xy(xy1),
        .tx_ready(tx_ready), .tx_data(txd1), .tx_valid(txv1), .busy(busy1), .done(done1)
    );

    // Board read ports: one and two register stages of latency.
    always @(posedge clk) begin
        code0 <= board[xy0];
        r1    <= board[xy1];
        code1 <= r1;
    end

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL dut%0d %s actual=%0h required=%0h t=%0t", i, nm, act, req, $time);
        end
    endtask

    task automatic mon(input int i, input logic v, input logic [7:0] d,
                       input logic b, input logic dn, input logic [6:0] xy);
        logic [7:0] e;
        bit         empty;
        int         sz;
        if (pv[i]) begin
            chk(i, "hold_valid", v, 1);
            chk(i, "hold_data", d, pd[i]);
            chk(i, "hold_xy", xy, pxy[i]);
        end
        if (xy != pxy[i] && xy != 7'd0) chk(i, "xy_order", xy, pxy[i] + 7'd1);
        if (int'(xy) > xy_max[i]) xy_max[i] = int'(xy);
        if (v && tx_ready) begin
            empty = 0;
            e     = 8'd0;
            if (i == 0) begin
                if (exp_q0.size() == 0) empty = 1; else e = exp_q0.pop_front();
            end else begin
                if (exp_q1.size() == 0) empty = 1; else e = exp_q1.pop_front();
            end
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL dut%0d extra_byte actual=%0h required=none t=%0t", i, d, $time);
            end else begin
                chk(i, "byte", d, e);
            end
            xfers[i]++;
        end
        pv[i]  = v && !tx_ready;
        pd[i]  = d;
        pxy[i] = xy;
        if (dn) begin
            sz = (i == 0) ? exp_q0.size() : exp_q1.size();
            dones[i]++;
            chk(i, "done_q_empty", sz, 0);
            chk(i, "frame_len", xfers[i], FRAME_LEN);
            chk(i, "done_busy", b, 0);
            chk(i, "xy_max", xy_max[i], 99);
            active[i] = 0;
            xfers[i]  = 0;
            xy_max[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pv[i] = 0; xfers[i] = 0; xy_max[i] = 0; pxy[i] = 7'd0; active[i] = 0;
            end
        end else begin
            mon(0, txv0, txd0, busy0, done0, xy0);
            mon(1, txv1, txd1, busy1, done1, xy1);
        end
    end

    task automatic build_frame();
        logic [7:0] x;
        int         b;
        frame[0] = 8'hA5;
        x        = 8'hA5;
        for (int j = 1; j <= 25; j++) begin
            b = 0;
            for (int l = 0; l < 4; l++) b += int'(board[4 * (j - 1) + l]) << (2 * l);
            frame[j] = 8'(b);
            x ^= frame[j];
        end
`ifdef BOARD_TX_CHECKSUM_EN
        frame[26] = x;
`endif
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        if (!active[0]) begin
            for (int j = 0; j < FRAME_LEN; j++) exp_q0.push_back(frame[j]);
            active[0] = 1;
        end
        if (!active[1]) begin
            for (int j = 0; j < FRAME_LEN; j++) exp_q1.push_back(frame[j]);
            active[1] = 1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int t;
        t = 0;
        while (xfers[0] < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk(0, "wait_bytes_timeout", (xfers[0] >= n), 1);
    endtask

    task automatic wait_done(input bit rand_ready);
        int d0, d1, t;
        d0 = dones[0];
        d1 = dones[1];
        t  = 0;
        while ((dones[0] == d0 || dones[1] == d1) && t < 5000) begin
            @(posedge clk); #1;
            if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
            t++;
        end
        tx_ready = 1'b1;
        chk(0, "frame_timeout", (t < 5000), 1);
        repeat (5) @(posedge clk);
        #1;
        chk(0, "done_once", dones[0], d0 + 1);
        chk(1, "done_once", dones[1], d1 + 1);
        chk(0, "busy_after", busy0, 0);
        chk(1, "busy_after", busy1, 0);
    endtask

    task automatic fill_board(input bit rnd);
        for (int c = 0; c < NC; c++) board[c] = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 2; i++) dones[i] = 0;
        fill_board(0);
        repeat (3) @(posedge clk);
        #1;
        chk(0, "rst_valid", txv0, 0);  chk(1, "rst_valid", txv1, 0);
        chk(0, "rst_busy", busy0, 0);  chk(1, "rst_busy", busy1, 0);
        chk(0, "rst_done", done0, 0);  chk(1, "rst_done", done1, 0);
        chk(0, "rst_xy", xy0, 0);      chk(1, "rst_xy", xy1, 0);
        chk(0, "rst_data", txd0, 0);   chk(1, "rst_data", txd1, 0);
        rst = 1'b0;

        // All-empty board.
        build_frame();
        chk(0, "pin_empty_b13", frame[13], 8'h00);
`ifdef BOARD_TX_CHECKSUM_EN
        chk(0, "pin_empty_csum", frame[26], 8'hA5);
`endif
        pulse_start();
        chk(0, "start_valid", txv0, 1);
        chk(0, "start_hdr", txd0, 8'hA5);
        chk(0, "start_busy", busy0, 1);
        wait_done(0);

        // Corner cells.
        board[0]  = 2'b01;
        board[99] = 2'b11;
        build_frame();
        chk(0, "pin_b1", frame[1], 8'h01);
        chk(0, "pin_b25", frame[25], 8'hC0);
`ifdef BOARD_TX_CHECKSUM_EN
        chk(0, "pin_csum", frame[26], 8'h64);
`endif
        pulse_start();
        wait_done(0);

        // Stall on the third byte.
        fill_board(1);
        build_frame();
        pulse_start();
        wait_bytes(2);
        tx_ready = 1'b0;
        for (int t = 0; t < 200 && !txv0; t++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
        chk(0, "stall_valid", txv0, 1);
        chk(0, "stall_count", xfers[0], 2);
        tx_ready = 1'b1;
        wait_done(0);

        // start re-pulsed mid-frame is ignored.
        fill_board(1);
        build_frame();
        pulse_start();
        wait_bytes(10);
        pulse_start();
        wait_done(0);

        // Reset mid-frame aborts without done.
        fill_board(1);
        build_frame();
        pulse_start();
        begin
            int d0, d1;
            d0 = dones[0];
            d1 = dones[1];
            wait_bytes(12);
            @(posedge clk); #1;
            rst = 1'b1;
            #1;
            chk(0, "abort_valid", txv0, 0);  chk(1, "abort_valid", txv1, 0);
            chk(0, "abort_busy", busy0, 0);  chk(1, "abort_busy", busy1, 0);
            exp_q0.delete();
            exp_q1.delete();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk(0, "abort_no_done", dones[0], d0);
            chk(1, "abort_no_done", dones[1], d1);
        end
        pulse_start();
        wait_done(0);

        // Single cell in lane 1 of byte 2.
        fill_board(0);
        board[5] = 2'b10;
        build_frame();
        chk(0, "pin_b2", frame[2], 8'h08);
        pulse_start();
        wait_done(0);

        // Random board with random back-pressure.
        fill_board(1);
        build_frame();
        pulse_start();
        wait_done(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
